// File: rtl/axi4_lite_rd_pipe.sv
// Pipelined AXI4-Lite read master with an in-order response FIFO.
// Optional watchdog: define AXI_RD_TIMEOUT_EN to add the rd_timeout flag.
module axi4_lite_rd_pipe #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_valid,
    output logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        rd_resp,
    output logic              rd_data_valid,
    input  logic              rd_data_ready,
    output logic [ADDR_W-1:0] s_axi_araddr,
    output logic              s_axi_arvalid,
    input  logic              s_axi_arready,
    input  logic [DATA_W-1:0] s_axi_rdata,
    input  logic [1:0]        s_axi_rresp,
    input  logic              s_axi_rvalid,
    output logic              s_axi_rready
`ifdef AXI_RD_TIMEOUT_EN
    ,
    output logic              rd_timeout
`endif
);

    localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned ENTRY_W = DATA_W + 2;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    // Elaboration-time parameter legality
    if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
        $error("DATA_W must be 32 or 64");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 16 ||
        (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_max_out
        $error("MAX_OUTSTANDING must be a power of 2 in 1..16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic {
        AR_IDLE,
        AR_BUSY
    } ar_state_t;

    ar_state_t        ar_state;
    logic [CNT_W-1:0] credits;
    logic [CNT_W-1:0] r_pending;
    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [ENTRY_W-1:0] fifo_mem [MAX_OUTSTANDING];

    logic accept;
    logic ar_hs;
    logic r_hs;
    logic pop;
    logic fifo_empty;
    logic fifo_full;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake decode and channel flow control
    assign fifo_empty    = (fifo_count == '0);
    assign fifo_full     = (fifo_count == CNT_MAX);
    assign s_axi_arvalid = (ar_state == AR_BUSY);
    assign rd_ready      = (!s_axi_arvalid || s_axi_arready) && (credits < CNT_MAX);
    assign s_axi_rready  = (r_pending != '0) && !fifo_full;
    assign accept        = rd_valid && rd_ready;
    assign ar_hs         = s_axi_arvalid && s_axi_arready;
    assign r_hs          = s_axi_rvalid && s_axi_rready;
    assign pop           = rd_data_valid && rd_data_ready;

    // First-word-fall-through head; zero while empty
    assign rd_data_valid = !fifo_empty;
    assign rd_data       = fifo_empty ? '0 : fifo_mem[rd_ptr][DATA_W-1:0];
    assign rd_resp       = fifo_empty ? '0 : fifo_mem[rd_ptr][ENTRY_W-1:DATA_W];

    // AR channel: one registered address slot, reloaded back-to-back on handshake
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            ar_state     <= AR_IDLE;
            s_axi_araddr <= '0;
        end else begin
            case (ar_state)
                AR_IDLE: begin
                    if (accept) begin
                        s_axi_araddr <= rd_addr;
                        ar_state     <= AR_BUSY;
                    end
                end
                AR_BUSY: begin
                    if (s_axi_arready) begin
                        if (accept) begin
                            s_axi_araddr <= rd_addr;
                        end else begin
                            s_axi_araddr <= '0;
                            ar_state     <= AR_IDLE;
                        end
                    end
                end
                default: begin
                    ar_state     <= AR_IDLE;
                    s_axi_araddr <= '0;
                end
            endcase
        end
    end

    // Credits bound accepted-but-unpopped reads so the FIFO cannot overflow
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            credits <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   credits <= credits + CNT_W'(1);
                2'b01:   credits <= credits - CNT_W'(1);
                default: credits <= credits;
            endcase
        end
    end

    // Reads issued on AR whose R beat has not yet arrived
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_pending <= '0;
        end else begin
            case ({ar_hs, r_hs})
                2'b10:   r_pending <= r_pending + CNT_W'(1);
                2'b01:   r_pending <= r_pending - CNT_W'(1);
                default: r_pending <= r_pending;
            endcase
        end
    end

    // Response FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (r_hs) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({r_hs, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Response FIFO storage; contents are don't-care while unoccupied
    always_ff @(posedge clk) begin
        if (r_hs) begin
            fifo_mem[wr_ptr] <= {s_axi_rresp, s_axi_rdata};
        end
    end

`ifdef AXI_RD_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_count;

    // Watchdog: counts stalled cycles with reads pending; flag is sticky until reset
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            wd_count   <= '0;
            rd_timeout <= 1'b0;
        end else if (r_hs || (r_pending == '0)) begin
            wd_count <= '0;
        end else if (wd_count != WD_W'(TIMEOUT_CYCLES)) begin
            wd_count <= wd_count + WD_W'(1);
            if (wd_count == WD_LAST) begin
                rd_timeout <= 1'b1;
            end
        end
    end
`endif

    // Structural invariants of the credit scheme
    a_fifo_overflow: assert property (@(posedge clk) disable iff (!arst_n)
        !(r_hs && fifo_full && !pop))
        else $error("response FIFO overflow");
    a_fifo_underflow: assert property (@(posedge clk) disable iff (!arst_n)
        !(pop && fifo_empty))
        else $error("response FIFO underflow");
    a_credit_overflow: assert property (@(posedge clk) disable iff (!arst_n)
        !(accept && !pop && credits == CNT_MAX))
        else $error("credit counter overflow");

endmodule

// File: tb/tb_axi4_lite_rd_pipe.sv
// Self-checking bench for axi4_lite_rd_pipe: directed scenarios plus a
// randomized run checked against a transaction-level scoreboard.
module tb_axi4_lite_rd_pipe;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MAX_OUT = 4;
    localparam int unsigned TO_CYC  = 16;

    logic              clk;
    logic              arst_n;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic [1:0]        rd_resp;
    logic              rd_data_valid;
    logic              rd_data_ready;
    logic [ADDR_W-1:0] s_axi_araddr;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [DATA_W-1:0] s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready;
`ifdef AXI_RD_TIMEOUT_EN
    logic              rd_timeout;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    axi4_lite_rd_pipe #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .MAX_OUTSTANDING(MAX_OUT),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .rd_addr      (rd_addr),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_resp      (rd_resp),
        .rd_data_valid(rd_data_valid),
        .rd_data_ready(rd_data_ready),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready)
`ifdef AXI_RD_TIMEOUT_EN
        ,
        .rd_timeout   (rd_timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something hangs despite the bounded waits
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required end before 2000000");
        $fatal(1, "global timeout");
    end

    // Slave data/response derived from the address
    function automatic logic [31:0] exp_data(input logic [31:0] a);
        return a ^ 32'hC3A5_5A3C ^ {a[15:0], a[31:16]};
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return a[5:4];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst_n        = 1'b0;
        rd_valid      = 1'b0;
        rd_addr       = '0;
        rd_data_ready = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rdata   = '0;
        s_axi_rresp   = '0;
        step();
        step();
        arst_n = 1'b1;
    endtask

    // Runs one complete read with bounded waits; ok=0 if any wait expires
    task automatic single_read(input logic [31:0] addr, input logic [31:0] data,
                               input logic [1:0] resp, output logic [31:0] got_d,
                               output logic [1:0] got_r, output bit ok);
        int k;
        ok    = 1'b1;
        got_d = '0;
        got_r = '0;
        rd_valid = 1'b1;
        rd_addr  = addr;
        #1;
        for (k = 0; k < 20 && !rd_ready; k++) step();
        if (!rd_ready) ok = 1'b0;
        step();
        rd_valid      = 1'b0;
        s_axi_arready = 1'b1;
        #1;
        for (k = 0; k < 20 && !s_axi_arvalid; k++) step();
        if (!s_axi_arvalid) ok = 1'b0;
        step();
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b1;
        s_axi_rdata   = data;
        s_axi_rresp   = resp;
        #1;
        for (k = 0; k < 20 && !s_axi_rready; k++) step();
        if (!s_axi_rready) ok = 1'b0;
        step();
        s_axi_rvalid  = 1'b0;
        rd_data_ready = 1'b1;
        #1;
        for (k = 0; k < 20 && !rd_data_valid; k++) step();
        if (!rd_data_valid) ok = 1'b0;
        got_d = rd_data;
        got_r = rd_resp;
        step();
        rd_data_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (s_axi_arvalid !== 1'b0 || s_axi_araddr !== '0 || s_axi_rready !== 1'b0) begin
            $display("FAIL reset_axi: arvalid=%b araddr=%h rready=%b, required 0/0/0",
                     s_axi_arvalid, s_axi_araddr, s_axi_rready);
            n_fail++;
        end
        n_checks++;
        if (rd_data_valid !== 1'b0 || rd_data !== '0 || rd_resp !== '0) begin
            $display("FAIL reset_fifo: valid=%b data=%h resp=%b, required 0/0/0",
                     rd_data_valid, rd_data, rd_resp);
            n_fail++;
        end
        n_checks++;
        if (rd_ready !== 1'b1) begin
            $display("FAIL reset_rd_ready: got %b, required 1", rd_ready);
            n_fail++;
        end
    endtask

    task automatic test_single_read();
        do_reset();
        rd_valid = 1'b1;
        rd_addr  = 32'h0000_1000;
        #1;
        n_checks++;
        if (rd_ready !== 1'b1) begin
            $display("FAIL single_accept: rd_ready=%b, required 1", rd_ready);
            n_fail++;
        end
        step();
        rd_valid = 1'b0;
        #1;
        n_checks++;
        if (s_axi_arvalid !== 1'b1 || s_axi_araddr !== 32'h0000_1000) begin
            $display("FAIL single_ar_c1: arvalid=%b araddr=%h, required 1/00001000",
                     s_axi_arvalid, s_axi_araddr);
            n_fail++;
        end
        step();
        s_axi_arready = 1'b1;
        #1;
        n_checks++;
        if (s_axi_arvalid !== 1'b1 || s_axi_araddr !== 32'h0000_1000) begin
            $display("FAIL single_ar_c2: arvalid=%b araddr=%h, required 1/00001000",
                     s_axi_arvalid, s_axi_araddr);
            n_fail++;
        end
        step();
        s_axi_arready = 1'b0;
        #1;
        n_checks++;
        if (s_axi_arvalid !== 1'b0 || s_axi_araddr !== '0 || s_axi_rready !== 1'b1) begin
            $display("FAIL single_ar_c3: arvalid=%b araddr=%h rready=%b, required 0/0/1",
                     s_axi_arvalid, s_axi_araddr, s_axi_rready);
            n_fail++;
        end
        step();
        s_axi_rvalid = 1'b1;
        s_axi_rdata  = 32'hDEAD_BEEF;
        s_axi_rresp  = 2'b00;
        #1;
        n_checks++;
        if (rd_data_valid !== 1'b0) begin
            $display("FAIL single_r_c4: rd_data_valid=%b, required 0", rd_data_valid);
            n_fail++;
        end
        step();
        s_axi_rvalid = 1'b0;
        #1;
        n_checks++;
        if (rd_data_valid !== 1'b1 || rd_data !== 32'hDEAD_BEEF || rd_resp !== 2'b00) begin
            $display("FAIL single_resp_c5: valid=%b data=%h resp=%b, required 1/deadbeef/00",
                     rd_data_valid, rd_data, rd_resp);
            n_fail++;
        end
        rd_data_ready = 1'b1;
        step();
        rd_data_ready = 1'b0;
        #1;
        n_checks++;
        if (rd_data_valid !== 1'b0 || rd_ready !== 1'b1) begin
            $display("FAIL single_after_pop: valid=%b rd_ready=%b, required 0/1",
                     rd_data_valid, rd_ready);
            n_fail++;
        end
    endtask

    task automatic test_pipelining();
        int idx;
        int n_ar;
        do_reset();
        s_axi_arready = 1'b1;
        rd_valid      = 1'b1;
        idx  = 0;
        n_ar = 0;
        for (int c = 0; c < 8; c++) begin
            rd_addr = 32'(idx * 4);
            #1;
            if (s_axi_arvalid && s_axi_arready) begin
                n_checks++;
                if (s_axi_araddr !== 32'(n_ar * 4)) begin
                    $display("FAIL pipe_ar_order: araddr=%h, required %h",
                             s_axi_araddr, 32'(n_ar * 4));
                    n_fail++;
                end
                n_ar++;
            end
            if (rd_valid && rd_ready) idx++;
            step();
        end
        #1;
        n_checks++;
        if (n_ar != 4 || idx != 4) begin
            $display("FAIL pipe_count: ar_issued=%0d accepted=%0d, required 4/4", n_ar, idx);
            n_fail++;
        end
        n_checks++;
        if (rd_ready !== 1'b0 || rd_addr !== 32'h10) begin
            $display("FAIL pipe_stall: rd_ready=%b pending_addr=%h, required 0/00000010",
                     rd_ready, rd_addr);
            n_fail++;
        end
        s_axi_rvalid = 1'b1;
        s_axi_rdata  = 32'h0000_00A0;
        s_axi_rresp  = 2'b00;
        #1;
        n_checks++;
        if (s_axi_rready !== 1'b1) begin
            $display("FAIL pipe_rready: got %b, required 1", s_axi_rready);
            n_fail++;
        end
        step();
        s_axi_rvalid  = 1'b0;
        rd_data_ready = 1'b1;
        #1;
        n_checks++;
        if (rd_data_valid !== 1'b1 || rd_data !== 32'h0000_00A0 || rd_ready !== 1'b0) begin
            $display("FAIL pipe_pop: valid=%b data=%h rd_ready=%b, required 1/000000a0/0",
                     rd_data_valid, rd_data, rd_ready);
            n_fail++;
        end
        step();
        rd_data_ready = 1'b0;
        #1;
        n_checks++;
        if (rd_ready !== 1'b1) begin
            $display("FAIL pipe_credit_back: rd_ready=%b, required 1", rd_ready);
            n_fail++;
        end
        step();
        rd_valid = 1'b0;
        #1;
        n_checks++;
        if (s_axi_arvalid !== 1'b1 || s_axi_araddr !== 32'h10) begin
            $display("FAIL pipe_fifth_ar: arvalid=%b araddr=%h, required 1/00000010",
                     s_axi_arvalid, s_axi_araddr);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        int acc;
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
        do_reset();
        s_axi_arready = 1'b1;
        rd_valid      = 1'b1;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            rd_addr = 32'(acc * 4);
            #1;
            if (rd_valid && rd_ready) acc++;
            step();
            if (acc == 4) rd_valid = 1'b0;
        end
        s_axi_arready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            s_axi_rvalid = 1'b1;
            s_axi_rdata  = vals[j];
            s_axi_rresp  = 2'b00;
            #1;
            n_checks++;
            if (s_axi_rready !== 1'b1) begin
                $display("FAIL b2b_rready_%0d: got %b, required 1", j, s_axi_rready);
                n_fail++;
            end
            step();
        end
        s_axi_rvalid = 1'b0;
        #1;
        n_checks++;
        if (rd_data_valid !== 1'b1 || rd_data !== 32'h11 || rd_ready !== 1'b0 ||
            s_axi_rready !== 1'b0) begin
            $display("FAIL b2b_full: valid=%b data=%h rd_ready=%b rready=%b, required 1/00000011/0/0",
                     rd_data_valid, rd_data, rd_ready, s_axi_rready);
            n_fail++;
        end
        rd_data_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            n_checks++;
            if (rd_data_valid !== 1'b1 || rd_data !== vals[j] || rd_resp !== 2'b00) begin
                $display("FAIL b2b_drain_%0d: valid=%b data=%h resp=%b, required 1/%h/00",
                         j, rd_data_valid, rd_data, rd_resp, vals[j]);
                n_fail++;
            end
            step();
        end
        rd_data_ready = 1'b0;
        #1;
        n_checks++;
        if (rd_data_valid !== 1'b0 || rd_ready !== 1'b1) begin
            $display("FAIL b2b_empty: valid=%b rd_ready=%b, required 0/1", rd_data_valid, rd_ready);
            n_fail++;
        end
    endtask

    task automatic test_error_passthru();
        logic [31:0] d;
        logic [1:0]  r;
        bit ok;
        do_reset();
        single_read(32'h0000_2000, 32'hBAD0_2000, 2'b10, d, r, ok);
        n_checks++;
        if (!ok || d !== 32'hBAD0_2000 || r !== 2'b10) begin
            $display("FAIL err_slverr: ok=%b data=%h resp=%b, required 1/bad02000/10", ok, d, r);
            n_fail++;
        end
        single_read(32'h0000_2004, 32'h0000_600D, 2'b00, d, r, ok);
        n_checks++;
        if (!ok || d !== 32'h0000_600D || r !== 2'b00) begin
            $display("FAIL err_following: ok=%b data=%h resp=%b, required 1/0000600d/00", ok, d, r);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  r;
        bit ok;
        int acc;
        do_reset();
        s_axi_arready = 1'b1;
        rd_valid      = 1'b1;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            rd_addr = 32'h100 + 32'(acc * 4);
            #1;
            if (rd_valid && rd_ready) acc++;
            step();
            if (acc == 3) rd_valid = 1'b0;
        end
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b1;
        s_axi_rdata   = 32'h55;
        step();
        s_axi_rvalid = 1'b0;
        #1;
        n_checks++;
        if (rd_data_valid !== 1'b1 || s_axi_rready !== 1'b1) begin
            $display("FAIL rstmid_pre: valid=%b rready=%b, required 1/1", rd_data_valid, s_axi_rready);
            n_fail++;
        end
        arst_n = 1'b0;
        step();
        arst_n = 1'b1;
        #1;
        n_checks++;
        if (s_axi_arvalid !== 1'b0 || s_axi_araddr !== '0 || s_axi_rready !== 1'b0 ||
            rd_data_valid !== 1'b0 || rd_data !== '0 || rd_resp !== '0 || rd_ready !== 1'b1) begin
            $display("FAIL rstmid_clear: arv=%b ara=%h rr=%b dv=%b d=%h rs=%b rdy=%b, required 0/0/0/0/0/0/1",
                     s_axi_arvalid, s_axi_araddr, s_axi_rready, rd_data_valid, rd_data, rd_resp, rd_ready);
            n_fail++;
        end
        s_axi_rvalid = 1'b1;
        s_axi_rdata  = 32'h77;
        #1;
        n_checks++;
        if (s_axi_rready !== 1'b0) begin
            $display("FAIL rstmid_late_rready: got %b, required 0", s_axi_rready);
            n_fail++;
        end
        step();
        s_axi_rvalid = 1'b0;
        #1;
        n_checks++;
        if (rd_data_valid !== 1'b0) begin
            $display("FAIL rstmid_late_ignored: rd_data_valid=%b, required 0", rd_data_valid);
            n_fail++;
        end
        single_read(32'h0000_3000, 32'h1234_ABCD, 2'b00, d, r, ok);
        n_checks++;
        if (!ok || d !== 32'h1234_ABCD || r !== 2'b00) begin
            $display("FAIL rstmid_recover: ok=%b data=%h resp=%b, required 1/1234abcd/00", ok, d, r);
            n_fail++;
        end
    endtask

    // Random traffic on both sides against a transaction-level model
    task automatic test_random();
        logic [31:0] issue_q[$];
        logic [31:0] slave_q[$];
        logic [31:0] sb_q[$];
        logic [31:0] a;
        int  fifo_n;
        bit  hold_rv;
        bit  stop;
        bit  exp_arv;
        bit  exp_rdy;
        bit  exp_rr;
        do_reset();
        fifo_n  = 0;
        hold_rv = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            stop          = (cyc >= 2400);
            rd_valid      = !stop && ($urandom_range(0, 3) != 0);
            rd_addr       = $urandom & 32'hFFFF_FFFC;
            rd_data_ready = ($urandom_range(0, 2) != 0);
            s_axi_arready = 1'($urandom_range(0, 1));
            if (!hold_rv) begin
                if (slave_q.size() != 0 && $urandom_range(0, 1) == 1) begin
                    s_axi_rvalid = 1'b1;
                    s_axi_rdata  = exp_data(slave_q[0]);
                    s_axi_rresp  = exp_resp(slave_q[0]);
                end else begin
                    s_axi_rvalid = 1'b0;
                    s_axi_rdata  = $urandom;
                    s_axi_rresp  = 2'($urandom_range(0, 3));
                end
            end
            #1;
            exp_arv = (issue_q.size() != 0);
            exp_rdy = (!exp_arv || s_axi_arready) && (sb_q.size() < MAX_OUT);
            exp_rr  = (slave_q.size() != 0) && (fifo_n < MAX_OUT);
            n_checks++;
            if (s_axi_arvalid !== exp_arv || rd_ready !== exp_rdy || s_axi_rready !== exp_rr ||
                rd_data_valid !== (fifo_n != 0)) begin
                $display("FAIL rand_flow cyc %0d: arv=%b rdy=%b rr=%b dv=%b, required %b/%b/%b/%b",
                         cyc, s_axi_arvalid, rd_ready, s_axi_rready, rd_data_valid,
                         exp_arv, exp_rdy, exp_rr, (fifo_n != 0));
                n_fail++;
            end
            if (rd_data_valid && sb_q.size() != 0) begin
                n_checks++;
                if (rd_data !== exp_data(sb_q[0]) || rd_resp !== exp_resp(sb_q[0])) begin
                    $display("FAIL rand_resp cyc %0d: data=%h resp=%b, required %h/%b",
                             cyc, rd_data, rd_resp, exp_data(sb_q[0]), exp_resp(sb_q[0]));
                    n_fail++;
                end
            end
            if (s_axi_arvalid && s_axi_arready && issue_q.size() != 0) begin
                a = issue_q.pop_front();
                n_checks++;
                if (s_axi_araddr !== a) begin
                    $display("FAIL rand_araddr cyc %0d: araddr=%h, required %h", cyc, s_axi_araddr, a);
                    n_fail++;
                end
                slave_q.push_back(a);
            end
            if (s_axi_rvalid && s_axi_rready) begin
                void'(slave_q.pop_front());
                fifo_n++;
                hold_rv = 1'b0;
            end else begin
                hold_rv = s_axi_rvalid;
            end
            if (rd_data_valid && rd_data_ready && sb_q.size() != 0) begin
                void'(sb_q.pop_front());
                fifo_n--;
            end
            if (rd_valid && rd_ready) begin
                issue_q.push_back(rd_addr);
                sb_q.push_back(rd_addr);
            end
            if (stop && sb_q.size() == 0) break;
            step();
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            $display("FAIL rand_drain: %0d responses outstanding, required 0", sb_q.size());
            n_fail++;
        end
        s_axi_rvalid  = 1'b0;
        rd_data_ready = 1'b0;
        rd_valid      = 1'b0;
    endtask

`ifdef AXI_RD_TIMEOUT_EN
    task automatic test_timeout();
        for (int scen = 0; scen < 2; scen++) begin
            do_reset();
            s_axi_arready = 1'b1;
            rd_valid      = 1'b1;
            rd_addr       = 32'h0000_4000;
            step();
            rd_valid = 1'b0;
            #1;
            n_checks++;
            if (s_axi_arvalid !== 1'b1) begin
                $display("FAIL to_ar_%0d: arvalid=%b, required 1", scen, s_axi_arvalid);
                n_fail++;
            end
            for (int k = 1; k <= 22; k++) begin
                step();
                s_axi_arready = 1'b0;
                if (scen == 1) begin
                    s_axi_rvalid = (k == 15);
                    s_axi_rdata  = 32'h5A5A;
                end
                #1;
                n_checks++;
                if (rd_timeout !== ((scen == 0) && (k >= 17))) begin
                    $display("FAIL to_flag_%0d step %0d: rd_timeout=%b, required %b",
                             scen, k, rd_timeout, ((scen == 0) && (k >= 17)));
                    n_fail++;
                end
            end
            s_axi_rvalid = 1'b0;
        end
    endtask
`endif

    initial begin
        arst_n        = 1'b0;
        rd_valid      = 1'b0;
        rd_addr       = '0;
        rd_data_ready = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rdata   = '0;
        s_axi_rresp   = '0;
        test_reset();
        test_single_read();
        test_pipelining();
        test_back_to_back();
        test_error_passthru();
        test_reset_mid();
        test_random();
`ifdef AXI_RD_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
